cis_line_seq: RTL and testbench
===============================

Name: cis_line_seq

Overview:
- Line/pixel timing sequencer for the CIS front end. Runs once the ADC serial configuration has completed.
- Drives the sensor start pulse (cis_sp), the ADC CDS clock (adc_cds) and the per-pixel data strobe (cis_wren).
- Sits between the top-level control (start_cis, sp_para) and the ADC/CIS pins, alongside adc_ctrl.

Parameters:
- PIX_PER_LINE, 432, valid pixels per line
- SP_WIDTH, 2, cis_sp high time in pixel periods
- DUMMY_PIX, 16, pixel periods after cis_sp ends and before the first valid pixel
- PIX_DIV, 4, adc_clk cycles per pixel period (even, >=2)

Ports:
- adc_clk  in  1  sequencer clock
- reset_n  in  1  asynchronous active-low reset
- init_done  in  1  ADC register configuration complete
- start_cis  in  1  level; high = run line sequence
- sp_para  in  16  requested line period in pixel periods
- cis_sp  out  1  sensor line start pulse
- adc_cds  out  1  ADC CDS clock
- cis_wren  out  1  one-cycle strobe per valid pixel
- pix_idx  out  12  index of valid pixel, 0..PIX_PER_LINE-1; meaningful only while cis_wren=1
- line_cnt  out  16  lines completed since leaving IDLE; wraps at 0xFFFF->0
- busy  out  1  state != IDLE
- err_period  out  1  sticky flag: sp_para below minimum

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- MIN_PERIOD = SP_WIDTH + DUMMY_PIX + PIX_PER_LINE.
- eff_period = max(sp_para, MIN_PERIOD).
  - sp_para is sampled only at line start.
  - If sp_para < MIN_PERIOD at that sample, err_period is set to 1 and stays 1 until the next entry to IDLE is followed by a clean line.
- Pixel divider div_cnt counts 0..PIX_DIV-1 while state is LINE.
  - adc_cds = 1 when div_cnt < PIX_DIV/2, registered.
  - Pixel tick = the cycle where div_cnt == PIX_DIV-1.
- Pixel counter pcnt runs 0..eff_period-1 and advances on each pixel tick.
- States:
  - IDLE: outputs low. Go to WAIT_INIT when start_cis=1.
  - WAIT_INIT: go to LINE when init_done=1. Return to IDLE if start_cis=0.
  - LINE:
    - cis_sp = 1 while pcnt < SP_WIDTH.
    - cis_wren = 1 on a pixel tick when SP_WIDTH+DUMMY_PIX <= pcnt < MIN_PERIOD.
    - pix_idx = pcnt - SP_WIDTH - DUMMY_PIX.
    - On the pixel tick with pcnt == eff_period-1: line_cnt increments. Then:
      - if start_cis=1, restart at pcnt=0 and resample sp_para;
      - otherwise go to IDLE.
- Latency:
  - From the LINE entry clock, cis_sp rises on the next edge (registered).
  - The first cis_wren occurs (SP_WIDTH+DUMMY_PIX)*PIX_DIV + PIX_DIV-1 cycles after LINE entry.
- start_cis drop mid-line: the current line completes fully; no new cis_sp is issued.
- init_done drop while in LINE: abort immediately.
  - Outputs go to 0 in the same cycle (registered next edge); the partial line is not counted.
  - State goes to WAIT_INIT.
- reset_n assertion mid-line: immediate return to reset values; no partial strobes after deassertion.
- Leaving IDLE clears line_cnt to 0.

Optional Feature:
- Macro: CIS_TEST_PATTERN_EN
- With the macro: extra output test_data (12 bits) = pix_idx XOR line_cnt[11:0], valid with cis_wren. Used for capture-path checks with no sensor attached.
- Without the macro: no port, no logic.

Decomposition:
- Package cis_seq_pkg holds:
  - the state enum (IDLE, WAIT_INIT, LINE);
  - the MIN_PERIOD computation;
  - pixel index width constant PIX_W=12.
- One sub-module, cis_pix_div: takes an enable, produces adc_cds and the pixel tick, clears div_cnt when disabled.

Test Plan:
Bench parameters: PIX_PER_LINE=8, SP_WIDTH=2, DUMMY_PIX=2, PIX_DIV=4, so MIN_PERIOD=12.
- Reset, start_cis=1, init_done=0 for 50 cycles -> busy=1; cis_sp, adc_cds, cis_wren all 0.
- init_done=1, sp_para=20 -> checks:
  - cis_sp high for 8 cycles;
  - 8 cis_wren strobes with pix_idx 0..7, spaced 4 cycles apart;
  - next cis_sp begins 80 cycles after the first;
  - line_cnt = 1 after the first line.
- sp_para=5 -> period is 12 pixels (48 cycles) and err_period=1.
- start_cis=0 at pixel 4 of line 3 -> line completes with all 8 strobes; line_cnt=3; then IDLE with busy=0; no further cis_sp.
- init_done=0 at pixel 6 -> outputs 0 on the next edge; line_cnt unchanged; state WAIT_INIT; when init_done returns high, a new line starts with pix_idx restarting at 0.
- reset_n low mid-line for 1 cycle -> all outputs 0 asynchronously; after release, no strobes until start_cis and init_done are high again.

Source files
------------

// File: rtl/cis_line_seq_pkg.sv
// rtl/cis_line_seq_pkg.sv - shared types and constants for the CIS line sequencer
//
// Purpose : state encoding, pixel index width and the minimum line period
//           helper used by cis_line_seq, its interface and its bench.
// Contents: PIX_W       - width of the valid-pixel index
//           cis_state_t - sequencer states (IDLE, WAIT_INIT, LINE)
//           min_period  - shortest legal line in pixel periods
package cis_seq_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_INIT = 2'd1,
    LINE      = 2'd2
  } cis_state_t;

  // A line must at least hold the start pulse, the dummy pixels and every
  // valid pixel; shorter requested periods are stretched to this.
  function automatic int min_period(input int pix_per_line, input int sp_width,
                                    input int dummy_pix);
    return sp_width + dummy_pix + pix_per_line;
  endfunction

endpackage

// File: rtl/cis_line_seq_if.sv
// rtl/cis_line_seq_if.sv - control/pin bundle between top-level control and the line sequencer
//
// Purpose : groups the sequencer's control inputs and CIS/ADC outputs.
// Modports: master - top-level control side (drives init_done, start_cis, sp_para)
//           slave  - the sequencer (drives cis_sp, adc_cds, cis_wren, pix_idx,
//                    line_cnt, busy, err_period)
// Option  : CIS_TEST_PATTERN_EN adds test_data (pix_idx ^ line_cnt[11:0]).
interface cis_line_seq_if;
  import cis_seq_pkg::*;

  logic             init_done;
  logic             start_cis;
  logic [15:0]      sp_para;
  logic             cis_sp;
  logic             adc_cds;
  logic             cis_wren;
  logic [PIX_W-1:0] pix_idx;
  logic [15:0]      line_cnt;
  logic             busy;
  logic             err_period;

`ifdef CIS_TEST_PATTERN_EN
  logic [PIX_W-1:0] test_data;

  modport master (
    output init_done, start_cis, sp_para,
    input  cis_sp, adc_cds, cis_wren, pix_idx, line_cnt, busy, err_period, test_data
  );

  modport slave (
    input  init_done, start_cis, sp_para,
    output cis_sp, adc_cds, cis_wren, pix_idx, line_cnt, busy, err_period, test_data
  );
`else
  modport master (
    output init_done, start_cis, sp_para,
    input  cis_sp, adc_cds, cis_wren, pix_idx, line_cnt, busy, err_period
  );

  modport slave (
    input  init_done, start_cis, sp_para,
    output cis_sp, adc_cds, cis_wren, pix_idx, line_cnt, busy, err_period
  );
`endif

endinterface

// File: rtl/cis_line_seq_pix_div.sv
// rtl/cis_line_seq_pix_div.sv - pixel-period divider producing the ADC CDS clock and pixel tick
//
// Purpose : divides adc_clk by PIX_DIV while enabled; held cleared when disabled.
// Ports   : clk      in  sequencer clock
//           rst_n    in  asynchronous active-low reset
//           en       in  count enable (sequencer in LINE with init_done high)
//           adc_cds  out CDS clock, high for the first half of each pixel period (registered)
//           pix_tick out high in the last cycle of each pixel period
//           pre_tick out high in the cycle before pix_tick
module cis_pix_div #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic adc_cds,
  output logic pix_tick,
  output logic pre_tick
);

  localparam int CW = $clog2(PIX_DIV);
  localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(PIX_DIV - 2);
  localparam logic [CW-1:0] HALF = CW'(PIX_DIV / 2);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      adc_cds <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      adc_cds <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
      adc_cds <= (div_cnt < HALF);
    end
  end

  assign pix_tick = en && (div_cnt == LAST);
  // One cycle of look-ahead lets the registered strobe line up with the tick.
  assign pre_tick = en && (div_cnt == PRE);

endmodule

// File: rtl/cis_line_seq.sv
// rtl/cis_line_seq.sv - line/pixel timing sequencer for the CIS front end
//
// Purpose : once ADC configuration is done, generates the sensor start pulse,
//           the ADC CDS clock and one data strobe per valid pixel, line after line.
// Ports   : adc_clk  in  sequencer clock
//           reset_n  in  asynchronous active-low reset
//           bus      slave modport of cis_line_seq_if:
//             init_done, start_cis, sp_para (in);
//             cis_sp, adc_cds, cis_wren, pix_idx, line_cnt, busy, err_period (out)
// Option  : CIS_TEST_PATTERN_EN drives bus.test_data = pix_idx ^ line_cnt[11:0]
//           alongside each strobe.
module cis_line_seq
  import cis_seq_pkg::*;
#(
  parameter int PIX_PER_LINE = 432,
  parameter int SP_WIDTH     = 2,
  parameter int DUMMY_PIX    = 16,
  parameter int PIX_DIV      = 4
) (
  input  logic          adc_clk,
  input  logic          reset_n,
  cis_line_seq_if.slave bus
);

  localparam int MIN_PERIOD = min_period(PIX_PER_LINE, SP_WIDTH, DUMMY_PIX);
  localparam logic [15:0] MIN_P16   = 16'(MIN_PERIOD);
  localparam logic [15:0] SP_END16  = 16'(SP_WIDTH);
  localparam logic [15:0] DATA_BEG16 = 16'(SP_WIDTH + DUMMY_PIX);

  cis_state_t       state;
  logic [15:0]      pcnt;
  logic [15:0]      eff_last;   // eff_period - 1 of the running line
  logic [15:0]      line_cnt;
  logic             err_period;
  logic             rearm;      // IDLE entered since last sample: a clean line may clear err
  logic             busy;
  logic             cis_sp;
  logic             cis_wren;
  logic [PIX_W-1:0] pix_idx;
`ifdef CIS_TEST_PATTERN_EN
  logic [PIX_W-1:0] test_data;
`endif

  logic div_en, pix_tick, pre_tick, adc_cds;

  // Abort on init_done loss takes effect on the same edge as the state change.
  assign div_en = (state == LINE) && bus.init_done;

  cis_pix_div #(.PIX_DIV(PIX_DIV)) u_pix_div (
    .clk      (adc_clk),
    .rst_n    (reset_n),
    .en       (div_en),
    .adc_cds  (adc_cds),
    .pix_tick (pix_tick),
    .pre_tick (pre_tick)
  );

  logic             sp_short;
  logic [15:0]      eff_last_new;
  logic             in_data;
  logic [PIX_W-1:0] idx_now;

  assign sp_short     = (bus.sp_para < MIN_P16);
  assign eff_last_new = (sp_short ? MIN_P16 : bus.sp_para) - 16'd1;
  assign in_data      = (pcnt >= DATA_BEG16) && (pcnt < MIN_P16);
  assign idx_now      = PIX_W'(pcnt - DATA_BEG16);

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pcnt       <= '0;
      eff_last   <= '0;
      line_cnt   <= '0;
      err_period <= 1'b0;
      rearm      <= 1'b0;
      busy       <= 1'b0;
      cis_sp     <= 1'b0;
      cis_wren   <= 1'b0;
      pix_idx    <= '0;
`ifdef CIS_TEST_PATTERN_EN
      test_data  <= '0;
`endif
    end else begin
      cis_sp   <= 1'b0;
      cis_wren <= 1'b0;
      pix_idx  <= '0;
`ifdef CIS_TEST_PATTERN_EN
      test_data <= '0;
`endif
      case (state)
        IDLE: begin
          pcnt <= '0;
          busy <= bus.start_cis;
          if (bus.start_cis) begin
            state    <= WAIT_INIT;
            line_cnt <= '0;
          end
        end

        WAIT_INIT: begin
          pcnt <= '0;
          if (!bus.start_cis) begin
            state <= IDLE;
            busy  <= 1'b0;
            rearm <= 1'b1;
          end else if (bus.init_done) begin
            state    <= LINE;
            eff_last <= eff_last_new;
            if (sp_short)   err_period <= 1'b1;
            else if (rearm) err_period <= 1'b0;
            rearm    <= 1'b0;
          end
        end

        LINE: begin
          if (!bus.init_done) begin
            // Partial line is dropped: no count, outputs low from the next edge.
            state <= WAIT_INIT;
            pcnt  <= '0;
          end else begin
            cis_sp <= (pcnt < SP_END16);
            if (pre_tick && in_data) begin
              cis_wren <= 1'b1;
              pix_idx  <= idx_now;
`ifdef CIS_TEST_PATTERN_EN
              test_data <= idx_now ^ PIX_W'(line_cnt);
`endif
            end
            if (pix_tick) begin
              if (pcnt == eff_last) begin
                line_cnt <= line_cnt + 16'd1;
                pcnt     <= '0;
                if (bus.start_cis) begin
                  eff_last <= eff_last_new;
                  if (sp_short)   err_period <= 1'b1;
                  else if (rearm) err_period <= 1'b0;
                  rearm    <= 1'b0;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  rearm <= 1'b1;
                end
              end else begin
                pcnt <= pcnt + 16'd1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cis_sp     = cis_sp;
  assign bus.adc_cds    = adc_cds;
  assign bus.cis_wren   = cis_wren;
  assign bus.pix_idx    = pix_idx;
  assign bus.line_cnt   = line_cnt;
  assign bus.busy       = busy;
  assign bus.err_period = err_period;
`ifdef CIS_TEST_PATTERN_EN
  assign bus.test_data  = test_data;
`endif

endmodule

// File: tb/tb_cis_line_seq.sv
// tb/tb_cis_line_seq.sv - directed self-checking bench for cis_line_seq
//
// Configuration: PIX_PER_LINE=8, SP_WIDTH=2, DUMMY_PIX=2, PIX_DIV=4 (MIN_PERIOD=12).
// Within a line, counted in cycles from the edge that starts it: cis_sp high at
// offsets 1..8, strobes at offsets 19,23,..,47 with pix_idx 0..7, adc_cds high
// when (offset-1)%4 is 0 or 1. Checks CIS_TEST_PATTERN_EN's test_data when defined.
module tb_cis_line_seq;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  cis_line_seq_if bus ();

  cis_line_seq #(
    .PIX_PER_LINE (8),
    .SP_WIDTH     (2),
    .DUMMY_PIX    (2),
    .PIX_DIV      (4)
  ) dut (
    .adc_clk (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  localparam int SP_LAST  = 8;   // SP_WIDTH*PIX_DIV
  localparam int WR_FIRST = 19;  // (SP_WIDTH+DUMMY_PIX)*PIX_DIV + PIX_DIV-1
  localparam int WR_LAST  = 47;  // WR_FIRST + 7*PIX_DIV

  int nvec = 0;
  int nerr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // active=0 means every pin output is expected low (IDLE, WAIT_INIT, abort).
  task automatic check_cycle(input string ph, input int n, input bit active, input int off,
                             input int lc, input logic bz, input logic er);
    logic sp, cds, wr;
    logic [15:0] idx;
    string t;
    t = $sformatf("%s@%0d", ph, n);
    if (active) begin
      sp  = (off >= 1) && (off <= SP_LAST);
      cds = (off >= 1) && (((off - 1) % 4) < 2);
      wr  = (off >= WR_FIRST) && (off <= WR_LAST) && (((off - WR_FIRST) % 4) == 0);
      idx = wr ? 16'((off - WR_FIRST) / 4) : 16'd0;
    end else begin
      sp = 1'b0; cds = 1'b0; wr = 1'b0; idx = 16'd0;
    end
    chk_b({t, " cis_sp"},   bus.cis_sp,   sp);
    chk_b({t, " adc_cds"},  bus.adc_cds,  cds);
    chk_b({t, " cis_wren"}, bus.cis_wren, wr);
    if (wr) begin
      chk_w({t, " pix_idx"}, 16'(bus.pix_idx), idx);
`ifdef CIS_TEST_PATTERN_EN
      chk_w({t, " test_data"}, 16'(bus.test_data), (idx ^ 16'(lc)) & 16'h0fff);
`endif
    end
    chk_w({t, " line_cnt"}, bus.line_cnt, 16'(lc));
    chk_b({t, " busy"},     bus.busy,     bz);
    chk_b({t, " err"},      bus.err_period, er);
  endtask

  initial begin
    int ls, lc;

    // Reset
    reset_n       = 1'b0;
    bus.start_cis = 1'b0;
    bus.init_done = 1'b0;
    bus.sp_para   = 16'd0;
    repeat (3) tick();
    check_cycle("reset", 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk_w("reset pix_idx", 16'(bus.pix_idx), 16'd0);

    // Waiting for ADC configuration: busy, pins quiet
    reset_n       = 1'b1;
    bus.start_cis = 1'b1;
    bus.sp_para   = 16'd20;
    for (int i = 1; i <= 50; i++) begin
      tick();
      check_cycle("wait_init", i, 1'b0, 0, 0, 1'b1, 1'b0);
    end

    // Line 1: 20 px (80 cycles); line 2,3: sp_para=5 -> 12 px (48 cycles);
    // start_cis drops at pixel 4 of line 3, which ends at k=176.
    bus.init_done = 1'b1;
    tick();
    check_cycle("run", 0, 1'b1, 0, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 230; k++) begin
      tick();
      ls = (k >= 128) ? 128 : (k >= 80) ? 80 : 0;
      lc = (k >= 176) ? 3 : (k >= 128) ? 2 : (k >= 80) ? 1 : 0;
      check_cycle("run", k, k < 176, k - ls, lc, k < 176, k >= 80);
      if (k == 40)  bus.sp_para   = 16'd5;
      if (k == 145) bus.start_cis = 1'b0;
    end

    // Restart from IDLE with a clean period (clears err), then drop init_done
    // at pixel 6, then recover and finish one full line into the next.
    bus.sp_para   = 16'd20;
    bus.start_cis = 1'b1;
    tick();
    check_cycle("abort", -1, 1'b0, 0, 0, 1'b1, 1'b1);
    tick();
    check_cycle("abort", 0, 1'b1, 0, 0, 1'b1, 1'b0);
    for (int m = 1; m <= 135; m++) begin
      tick();
      if (m <= 25)
        check_cycle("abort", m, 1'b1, m, 0, 1'b1, 1'b0);
      else if (m <= 40)
        check_cycle("abort", m, 1'b0, 0, 0, 1'b1, 1'b0);
      else if (m < 121)
        check_cycle("abort", m, 1'b1, m - 41, 0, 1'b1, 1'b0);
      else
        check_cycle("abort", m, 1'b1, m - 121, 1, 1'b1, 1'b0);
      if (m == 25) bus.init_done = 1'b0;
      if (m == 40) bus.init_done = 1'b1;
    end

    // Asynchronous reset mid-line
    reset_n = 1'b0;
    #1;
    check_cycle("async_rst", 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk_w("async_rst pix_idx", 16'(bus.pix_idx), 16'd0);
    bus.start_cis = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      check_cycle("post_rst", i, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    bus.start_cis = 1'b1;
    tick();
    check_cycle("rerun", -1, 1'b0, 0, 0, 1'b1, 1'b0);
    tick();
    check_cycle("rerun", 0, 1'b1, 0, 0, 1'b1, 1'b0);
    for (int q = 1; q <= 25; q++) begin
      tick();
      check_cycle("rerun", q, 1'b1, q, 0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
